// File: rtl/uart_tx_rr_sched.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter.
// Each bit lasts OVS b_tick pulses; a frame starts on accept without waiting for a tick.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | line high, req_ready offers the round-robin winner
// ST_START | start bit (tx=0) for OVS ticks
// ST_DATA  | eight data bits, LSB first, OVS ticks each
// ST_STOP  | stop bit (tx=1); frame_done pulses when it ends
module uart_tx_rr_sched #(
    parameter int NUM_REQ = 2,
    parameter int OVS     = 16,
    localparam int IDW    = $clog2(NUM_REQ),
    localparam int TCW    = $clog2(OVS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [IDW-1:0]       grant_id,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 frame_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]     state;
    logic [TCW-1:0] tick_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic [IDW-1:0] rr_ptr;

    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] next_ptr;
    logic [7:0]     win_data;
    logic           bit_end;

    // rr_ptr is the first index searched; it is kept apart from grant_id so that
    // reset can give requester 0 priority while grant_id also reads 0.
    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        winner   = '0;
        next_ptr = '0;
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                winner   = IDW'(idx);
                next_ptr = IDW'((idx + 1) % NUM_REQ);
                win_data = req_data[8*idx +: 8];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst && state == ST_IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign bit_end = b_tick && (tick_cnt == TCW'(OVS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rr_ptr     <= '0;
            grant_id   <= '0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (found) begin
                    shreg    <= win_data;
                    grant_id <= winner;
                    rr_ptr   <= next_ptr;
                    state    <= ST_START;
                    tick_cnt <= '0;
                    tx       <= 1'b0;
                    tx_busy  <= 1'b1;
                end
            end else if (b_tick) begin
                if (bit_end) begin
                    tick_cnt <= '0;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
                if (bit_end) begin
                    case (state)
                        ST_START: begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            tx      <= shreg[0];
                        end
                        ST_DATA: begin
                            // shreg[0] always holds the bit currently on the line
                            if (bit_cnt != 3'd7) begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx      <= shreg[1];
                                shreg   <= {1'b0, shreg[7:1]};
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end
                        ST_STOP: begin
                            state      <= ST_IDLE;
                            tx_busy    <= 1'b0;
                            frame_done <= 1'b1;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_rr_sched.sv
// Directed bench for uart_tx_rr_sched: NUM_REQ=2, OVS=16, b_tick every 4 clocks
// except in the fast-tick step where it is high every clock.
module tb_uart_tx_rr_sched;

    logic        clk;
    logic        rst;
    logic        b_tick;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [0:0]  grant_id;
    logic        tx;
    logic        tx_busy;
    logic        frame_done;

    int n_chk  = 0;
    int n_pass = 0;
    bit fast   = 1'b0;
    int tcnt   = 0;
    int nclk;

    uart_tx_rr_sched #(.NUM_REQ(2), .OVS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .b_tick     (b_tick),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .grant_id   (grant_id),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial b_tick = 1'b0;
    always @(negedge clk) begin
        if (fast) begin
            b_tick = 1'b1;
        end else begin
            b_tick = (tcnt == 3);
            tcnt   = (tcnt + 1) % 4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_ticks(input int n, input string tag);
        int t;
        int c;
        logic bt;
        t = 0;
        c = 0;
        while (t < n && c < 2000) begin
            @(posedge clk);
            bt = b_tick;
            #1;
            c++;
            if (bt) t++;
        end
        chk(tag, t, n);
    endtask

    // Called one step after the accepting edge; returns one step after the edge
    // on which the stop bit ends (frame_done high, line idle).
    task automatic run_frame(input logic [7:0] b, input string tag, output int clks);
        logic [9:0] fb;
        logic [9:0] bad;
        bit         busy_bad;
        bit         early_done;
        bit         rdy_bad;
        logic       bt;
        int         t;
        fb         = {1'b1, b, 1'b0};
        bad        = '0;
        busy_bad   = 1'b0;
        early_done = 1'b0;
        rdy_bad    = 1'b0;
        t          = 0;
        clks       = 0;
        while (t < 160 && clks < 3000) begin
            @(posedge clk);
            bt = b_tick;
            #1;
            clks++;
            if (bt) t++;
            if (t < 160) begin
                if (tx !== fb[t/16]) bad[t/16] = 1'b1;
                if (tx_busy !== 1'b1) busy_bad = 1'b1;
                if (frame_done !== 1'b0) early_done = 1'b1;
                if (req_ready !== 2'b00) rdy_bad = 1'b1;
            end
        end
        chk({tag, "_ticks"}, t, 160);
        chk({tag, "_bad_bits"}, bad, 10'h000);
        chk({tag, "_busy_drop"}, busy_bad, 0);
        chk({tag, "_early_done"}, early_done, 0);
        chk({tag, "_ready_in_frame"}, rdy_bad, 0);
        chk({tag, "_end_tx"}, tx, 1);
        chk({tag, "_end_busy"}, tx_busy, 0);
        chk({tag, "_end_done"}, frame_done, 1);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_grant", grant_id, 0);
        chk("rst_done", frame_done, 0);
        rst = 1'b1;

        // single requester, 0xA5
        @(negedge clk);
        req_data[7:0] = 8'hA5;
        req_valid     = 2'b01;
        #1;
        chk("single_ready", req_ready, 2'b01);
        @(posedge clk);
        #1;
        chk("single_start_tx", tx, 0);
        chk("single_start_busy", tx_busy, 1);
        chk("single_grant", grant_id, 0);
        chk("single_ready_drop", req_ready, 2'b00);
        req_valid = 2'b00;
        run_frame(8'hA5, "single", nclk);
        @(posedge clk);
        #1;
        chk("single_done_pulse", frame_done, 0);

        // contention straight after reset: requester 0 wins first
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        req_data  = 16'h2211;
        req_valid = 2'b11;
        #1;
        chk("cont_ready0", req_ready, 2'b01);
        @(posedge clk);
        #1;
        chk("cont_grant0", grant_id, 0);
        req_valid = 2'b10;
        run_frame(8'h11, "cont0", nclk);
        chk("cont_ready1_at_done", req_ready, 2'b10);
        @(posedge clk);
        #1;
        chk("cont_grant1", grant_id, 1);
        chk("cont_start1_tx", tx, 0);
        chk("cont_done_pulse", frame_done, 0);
        req_valid = 2'b00;
        run_frame(8'h22, "cont1", nclk);
        req_valid = 2'b11;
        #1;
        chk("cont_wrap_ready", req_ready, 2'b01);
        @(posedge clk);
        #1;
        chk("cont_wrap_grant", grant_id, 0);
        req_valid = 2'b00;
        run_frame(8'h11, "cont_wrap", nclk);

        // hold-off: requester 1 raises valid mid-frame, then changes data after accept
        req_data[7:0] = 8'h3C;
        req_valid     = 2'b01;
        @(posedge clk);
        #1;
        chk("hold_grant0", grant_id, 0);
        req_data[15:8] = 8'h5A;
        req_valid      = 2'b10;
        run_frame(8'h3C, "hold0", nclk);
        chk("hold_ready_idle", req_ready, 2'b10);
        @(posedge clk);
        #1;
        chk("hold_grant1", grant_id, 1);
        req_data[15:8] = 8'hFF;
        req_valid      = 2'b00;
        run_frame(8'h5A, "hold1", nclk);

        // fast tick: one b_tick per clock
        fast          = 1'b1;
        req_data[7:0] = 8'h96;
        req_valid     = 2'b01;
        #1;
        chk("fast_ready", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        run_frame(8'h96, "fast", nclk);
        chk("fast_frame_clks", nclk, 160);
        fast = 1'b0;

        // abort during data bit 3, then resend a pending byte
        @(negedge clk);
        req_data[7:0] = 8'hC3;
        req_valid     = 2'b01;
        @(posedge clk);
        #1;
        chk("abort_grant", grant_id, 0);
        req_data[7:0] = 8'h3A;
        wait_ticks(72, "abort_wait");
        chk("abort_bit3_tx", tx, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", tx_busy, 0);
        chk("abort_ready", req_ready, 2'b00);
        chk("abort_grant_rst", grant_id, 0);
        chk("abort_done", frame_done, 0);
        @(negedge clk);
        chk("abort_no_done", frame_done, 0);
        rst = 1'b1;
        #1;
        chk("abort_resume_ready", req_ready, 2'b01);
        @(posedge clk);
        #1;
        chk("abort_resume_tx", tx, 0);
        chk("abort_resume_grant", grant_id, 0);
        req_valid = 2'b00;
        run_frame(8'h3A, "resume", nclk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
